// File: rtl/column_driver.sv
// column_driver: one-at-a-time LED column drive with anti-ghost blanking and overrun detection
// Ports:
//   clk_33        33.33 MHz system clock
//   rst           asynchronous active-high reset
//   enable        low forces all columns off and aborts a drive in progress
//   restart       synchronous return to column 0, clears overrun
//   column_ready  framebuffer has the next column loaded (pulse or level)
//   mux_out       active-low column select, registered, at most one bit low
//   column_idx    column to be displayed next / currently displayed
//   column_done   pulse in the first all-off cycle after a completed drive window
//   frame_done    pulse coincident with column_done for the last column
//   overrun       sticky: column_ready seen while a column was being serviced
// Build option: define COLUMN_DRIVER_ANTIGHOST_EN to insert the GHOST dead time after each column.
module column_driver #(
    parameter int N_COLUMNS    = 8,
    parameter int DRIVE_CYCLES = 330,
    parameter int GHOST_CYCLES = 10
) (
    input  logic                         clk_33,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         restart,
    input  logic                         column_ready,
    output logic [N_COLUMNS-1:0]         mux_out,
    output logic [$clog2(N_COLUMNS)-1:0] column_idx,
    output logic                         column_done,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int IW   = $clog2(N_COLUMNS);
    localparam int CMAX = DRIVE_CYCLES > GHOST_CYCLES ? DRIVE_CYCLES : GHOST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [IW-1:0] LAST  = IW'(N_COLUMNS - 1);
    localparam logic [CW-1:0] DLAST = CW'(DRIVE_CYCLES - 1);

    typedef enum logic [1:0] {WAIT, DISP, GHOST} state_t;

`ifdef COLUMN_DRIVER_ANTIGHOST_EN
    localparam state_t POST = GHOST;
    localparam logic [CW-1:0] GLAST = CW'(GHOST_CYCLES - 1);
`else
    localparam state_t POST = WAIT;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_COLUMNS-1:0] mux_q, mux_d;
    logic                 done_q, done_d, frame_q, frame_d, ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        frame_d = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            WAIT: state_d = enable && column_ready ? DISP : WAIT;
            DISP: begin
                ovr_d = ovr_q | (enable & column_ready);
                if (!enable) begin
                    state_d = POST;
                end else if (cnt_q == DLAST) begin
                    state_d = POST;
                    idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
                    done_d  = 1'b1;
                    frame_d = idx_q == LAST;
                end
            end
`ifdef COLUMN_DRIVER_ANTIGHOST_EN
            GHOST: begin
                ovr_d   = ovr_q | (enable & column_ready);
                state_d = cnt_q == GLAST ? WAIT : GHOST;
            end
`endif
            default: state_d = WAIT;
        endcase
        if (restart) begin
            state_d = WAIT;
            idx_d   = '0;
            done_d  = 1'b0;
            frame_d = 1'b0;
            ovr_d   = 1'b0;
        end
        // cleared on every state entry, so it never needs to wrap
        cnt_d = (state_d != state_q || state_d == WAIT) ? '0 : cnt_q + 1'b1;
        // derived from the next state so the select is a clean flop output
        mux_d = state_d == DISP ? ~({{(N_COLUMNS-1){1'b0}}, 1'b1} << idx_d) : '1;
    end

    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            mux_q   <= '1;
            done_q  <= 1'b0;
            frame_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mux_q   <= mux_d;
            done_q  <= done_d;
            frame_q <= frame_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mux_out     = mux_q;
    assign column_idx  = idx_q;
    assign column_done = done_q;
    assign frame_done  = frame_q;
    assign overrun     = ovr_q;
endmodule
